// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded RV32I instruction fields into 32-bit machine
// words and streams them into an instruction memory at consecutive word
// addresses through a 2-entry FIFO.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   clear                      sync flush of FIFO, address, word/illegal counts
//   in_valid/in_ready          request handshake
//   in_op, in_funct3, in_funct7_5, in_rd, in_rs1, in_rs2, in_imm  request fields
//   imem_we/imem_addr/imem_wdata/imem_ready  memory write port
//   word_count                 words written since reset/clear
//   full                       1024 words written or queued
//   err_illegal, illegal_cnt   illegal-request pulse and saturating count
module instr_encoder #(
  parameter int unsigned CAP_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic [10:0] word_count,
  output logic        full,
  output logic        err_illegal,
  output logic [7:0]  illegal_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  state_t           state;
  logic [1:0][31:0] fifo_mem;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       occ, occ_nxt;
  logic             run;          // low until the first edge after reset
  logic [31:0]      enc;
  logic             illegal;
  logic             acc, push, pop;
  logic [10:0]      total_cur;

  // Field encoder
  always_comb begin
    enc     = '0;
    illegal = 1'b0;
    unique case (in_op)
      4'd0: enc = {1'b0, in_funct7_5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd1: begin
        // shifts carry the shamt plus the arithmetic/logical select bit
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc = {1'b0, in_funct7_5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      4'd2: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd3: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd4: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:1], in_imm[11], 7'b1100011};
        illegal = (in_funct3 == 3'b010) || (in_funct3 == 3'b011) || in_imm[0];
      end
      4'd5: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        illegal = in_imm[0];
      end
      4'd6: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111};
        illegal = (in_funct3 != 3'b000);
      end
      4'd7: enc = {in_imm[31:12], in_rd, 7'b0110111};
      4'd8: enc = {in_imm[31:12], in_rd, 7'b0010111};
      default: illegal = 1'b1;
    endcase
  end

  assign full       = (state == FULL);
  assign in_ready   = run & ~full & (occ != 2'd2) & ~clear;
  assign imem_we    = (occ != 2'd0);
  assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : '0;

  assign acc       = in_valid & in_ready;
  assign push      = acc & ~illegal;
  assign pop       = imem_we & imem_ready & ~clear;
  assign occ_nxt   = occ + {1'b0, push} - {1'b0, pop};
  // written + queued; a pop only moves a word between the two terms
  assign total_cur = word_count + {9'b0, occ};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fifo_mem    <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occ         <= '0;
      run         <= 1'b0;
      imem_addr   <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (clear) begin
        state       <= IDLE;
        rd_ptr      <= 1'b0;
        wr_ptr      <= 1'b0;
        occ         <= '0;
        imem_addr   <= '0;
        word_count  <= '0;
        err_illegal <= 1'b0;
        illegal_cnt <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= enc;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr     <= ~rd_ptr;
          word_count <= word_count + 11'd1;
          // hold at the last word rather than wrapping onto address 0
          if (imem_addr != 10'h3FF) imem_addr <= imem_addr + 10'd1;
        end
        occ         <= occ_nxt;
        err_illegal <= acc & illegal;
        if (acc && illegal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
        unique case (state)
          FULL: state <= FULL;
          default: begin
            if (total_cur + {10'b0, push} == 11'(CAP_WORDS)) state <= FULL;
            else if (occ_nxt != 2'd0)                        state <= BUSY;
            else                                             state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk, rst_n, clear, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        imem_we, imem_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_count;
  logic        full, err_illegal;
  logic [7:0]  illegal_cnt;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .word_count(word_count), .full(full),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] q[$];
  int          exp_addr = 0, exp_wc = 0, exp_ill = 0, err_seen = 0;
  bit          rand_rdy = 0;
  bit          prev_stall = 0;
  logic [31:0] hold_a, hold_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---- reference model: RV32I field placement by plain shifts ----
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  function automatic logic [31:0] ref_word(input int op, f3, f7, rd, rs1, rs2, input logic [31:0] imm);
    logic [31:0] o, r, a, b, d;
    o = 32'(f3) << 12; r = 32'(rd) << 7; a = 32'(rs1) << 15; b = 32'(rs2) << 20; d = 32'(f7) << 30;
    case (op)
      0: return d | b | a | o | r | 32'h33;
      1: if (f3 == 1 || f3 == 5) return d | (fld(imm, 4, 0) << 20) | a | o | r | 32'h13;
         else return (fld(imm, 11, 0) << 20) | a | o | r | 32'h13;
      2: return (fld(imm, 11, 0) << 20) | a | o | r | 32'h03;
      3: return (fld(imm, 11, 5) << 25) | b | a | o | (fld(imm, 4, 0) << 7) | 32'h23;
      4: return (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | b | a | o |
                (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
      5: return (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
                (fld(imm, 19, 12) << 12) | r | 32'h6F;
      6: return (fld(imm, 11, 0) << 20) | a | o | r | 32'h67;
      7: return (imm & 32'hFFFFF000) | r | 32'h37;
      8: return (imm & 32'hFFFFF000) | r | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_ill(input int op, f3, input logic [31:0] imm);
    if (op >= 9) return 1;
    if (op == 4 && (f3 == 2 || f3 == 3 || imm[0])) return 1;
    if (op == 5 && imm[0]) return 1;
    if (op == 6 && f3 != 0) return 1;
    return 0;
  endfunction

  // ---- stimulus helpers ----
  task automatic send(input int op, f3, f7, rd, rs1, rs2, input logic [31:0] imm);
    int n;
    @(negedge clk);
    in_op = 4'(op); in_funct3 = 3'(f3); in_funct7_5 = 1'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      n_bad++; $display("FAIL send_timeout: in_ready stayed 0 required 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ref_ill(op, f3, imm)) exp_ill++;
      else q.push_back(ref_word(op, f3, f7, rd, rs1, rs2, imm));
    end
  endtask

  task automatic set_rdy(input logic v);
    rand_rdy = 0;
    @(posedge clk); #1;
    imem_ready = v;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || imem_we) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      n_bad++; $display("FAIL drain_timeout: %0d words still expected, required 0", q.size());
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #2;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    q.delete(); exp_addr = 0; exp_wc = 0; exp_ill = 0; err_seen = 0;
  endtask

  task automatic reset_model();
    q.delete(); exp_addr = 0; exp_wc = 0; exp_ill = 0; err_seen = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", imem_we, 0);        chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);  chk("rst_wc", word_count, 0);
    chk("rst_full", full, 0);         chk("rst_err", err_illegal, 0);
    chk("rst_icnt", illegal_cnt, 0);  chk("rst_ready", in_ready, 0);
  endtask

  // ---- monitor / scoreboard ----
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (prev_stall && imem_we) begin
        chk("hold_addr", 32'(imem_addr), hold_a);
        chk("hold_data", imem_wdata, hold_d);
      end
      prev_stall = imem_we && !imem_ready && !clear;
      hold_a = 32'(imem_addr); hold_d = imem_wdata;
      if (err_illegal) err_seen++;
      if (imem_we && imem_ready && !clear) begin
        if (q.size() == 0) begin
          n_bad++; $display("FAIL unexpected_write: data 0x%0h with empty scoreboard", imem_wdata);
        end else begin
          chk("wdata", imem_wdata, q.pop_front());
          chk("waddr", 32'(imem_addr), 32'(exp_addr));
          if (exp_addr != 1023) exp_addr++;
          exp_wc++;
        end
      end
    end else prev_stall = 0;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) imem_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---- main sequence ----
  initial begin
    logic [31:0] w0;
    int op, f3;
    logic [31:0] imm;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    in_op = '0; in_funct3 = '0; in_funct7_5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", in_ready, 0);
    @(posedge clk); #1 chk("ready_after_edge", in_ready, 1);

    // ADD / SUB
    set_rdy(1);
    send(0, 0, 0, 3, 1, 2, 0);
    send(0, 0, 1, 3, 1, 2, 0);
    drain();
    chk("add_sub_wc", word_count, 2);
    // ADDI, SW, BEQ ; LUI, JAL
    send(1, 0, 0, 1, 0, 0, 5);
    send(3, 2, 0, 0, 1, 2, 12);
    send(4, 0, 0, 0, 1, 2, 8);
    send(7, 0, 0, 5, 0, 0, 32'h12345000);
    send(5, 0, 0, 1, 0, 0, 16);
    drain();
    @(negedge clk);
    chk("directed_wc", word_count, 32'(exp_wc));
    chk("directed_addr", imem_addr, 7);

    // back-pressure: two words fit, then stall
    set_rdy(0);
    send(2, 2, 0, 4, 6, 0, 32'h0000_0FFC);
    send(8, 0, 0, 9, 0, 0, 32'hABCDE123);
    @(negedge clk);
    chk("bp_ready", in_ready, 0);
    chk("bp_we", imem_we, 1);
    w0 = q[0];
    chk("bp_head", imem_wdata, w0);
    repeat (3) @(negedge clk);
    chk("bp_head_stable", imem_wdata, w0);
    set_rdy(1);
    drain();
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_wc", word_count, 32'(exp_wc));

    // illegal requests
    send(12, 0, 0, 1, 1, 1, 0);
    send(4, 0, 0, 0, 1, 2, 3);
    repeat (2) @(negedge clk);
    chk("ill_pulses", 32'(err_seen), 2);
    chk("ill_cnt", illegal_cnt, 2);
    chk("ill_wc", word_count, 32'(exp_wc));
    chk("ill_we", imem_we, 0);

    // randomized traffic with random memory back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 120; i++) begin
      op = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 15));
      f3 = int'($urandom_range(0, 7));
      imm = $urandom;
      if ((op == 4 || op == 5) && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
      if (op == 6 && $urandom_range(0, 1) != 0) f3 = 0;
      send(op, f3, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
    end
    set_rdy(1);
    drain();
    repeat (2) @(negedge clk);
    chk("rand_wc", word_count, 32'(exp_wc));
    chk("rand_icnt", illegal_cnt, 32'(exp_ill));
    chk("rand_pulses", 32'(err_seen), 32'(exp_ill));

    // reset in the middle of a stalled write
    set_rdy(0);
    send(0, 7, 0, 8, 9, 10, 0);
    @(negedge clk);
    chk("mid_we", imem_we, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 chk("mid_ready", in_ready, 1);

    // fill all 1024 words, then flush
    set_rdy(1);
    for (int i = 0; i < 1024; i++)
      send(1, 0, 0, i % 32, (i / 32) % 32, 0, 32'(i));
    drain();
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_ready", in_ready, 0);
    chk("fill_wc", word_count, 1024);
    chk("fill_model_wc", 32'(exp_wc), 1024);
    chk("fill_addr", imem_addr, 1023);
    do_clear();
    @(negedge clk);
    chk("clr_wc", word_count, 0);
    chk("clr_full", full, 0);
    chk("clr_addr", imem_addr, 0);
    chk("clr_we", imem_we, 0);
    chk("clr_ready", in_ready, 1);

    // clear with a word in flight: no write follows
    set_rdy(0);
    send(7, 0, 0, 2, 0, 0, 32'hFFFFF000);
    do_clear();
    #1 chk("clr_inflight_we", imem_we, 0);
    set_rdy(1);
    @(negedge clk);
    chk("clr_inflight_wc", word_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
